// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg
//   Shared types for the byte packer: FSM state encoding, the output-queue
//   entry struct and the burst-length width.
//   The entry struct is sized from BP_DATA_W / BP_LANES. The top-level DATA_W
//   and LANES parameters default to these values and must be kept equal to them.
package byte_packer_pkg;

    localparam int BP_DATA_W = 8;
    localparam int BP_LANES  = 4;
    localparam int BP_LEN_W  = 16;

    typedef enum logic [1:0] {
        BP_IDLE_S,
        BP_FILL_S,
        BP_HOLD_S
    } bp_state_t;

    typedef struct packed {
        logic [BP_LANES*BP_DATA_W-1:0] data;
        logic [BP_LANES-1:0]           keep;
        logic                          last;
        logic [BP_LEN_W-1:0]           len;
    } bp_entry_t;

endpackage

// File: rtl/byte_packer_oq.sv
// byte_packer_oq
//   Two-entry valid/ready queue of bp_entry_t words. The head entry drives
//   the consumer side directly; a push and a pop in the same cycle are both
//   honoured even when the queue is full.
// Ports:
//   clk         clock
//   srst        synchronous active-high reset (empties the queue)
//   push        write push_entry this cycle (ignored when full without a pop)
//   push_entry  word to enqueue
//   pop_ready   consumer accepts the head when head_valid is high
//   head_valid  queue is not empty
//   head        head entry, zero when empty
//   full        queue holds DEPTH entries
module byte_packer_oq
    import byte_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      srst,
    input  logic      push,
    input  bp_entry_t push_entry,
    input  logic      pop_ready,
    output logic      head_valid,
    output bp_entry_t head,
    output logic      full
);

    // Pointers are one bit wide: the queue is fixed at two entries.
    bp_entry_t  mem [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    logic pop;
    logic wr_en;

    assign head_valid = (count_reg != 2'd0);
    assign full       = (count_reg == 2'(DEPTH));
    assign pop        = head_valid && pop_ready;
    // When full, the write slot is the head slot; it may only be reused if the
    // head leaves in this same cycle.
    assign wr_en      = push && (!full || pop);
    assign head       = head_valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_reg] <= push_entry;
                wr_ptr_reg      <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/byte_packer.sv
// byte_packer
//   Packs unthrottled byte bursts into LANES-byte little-endian words and
//   emits them on a valid/ready stream with a keep mask and end-of-burst flag.
//   A burst ends after GAP consecutive idle input cycles. Input is never
//   stalled; a word that finds the output queue full is dropped and the
//   sticky overflow flag is raised.
//   Optional macro BYTE_PACKER_LEN_EN: when defined, burst_len reports the
//   byte count of the burst while its last word is at the head; otherwise
//   burst_len is constant zero and no byte counter is built.
// Ports:
//   clk_b      clock
//   rst        synchronous active-high reset
//   in_valid   byte qualifier
//   in_data    byte
//   out_valid  output word valid
//   out_ready  downstream accept
//   out_data   packed word, first byte in lane 0
//   out_keep   contiguous lane-valid mask from lane 0
//   out_last   final word of a burst
//   overflow   sticky word-dropped flag
//   burst_len  completed-burst byte count (see macro above)
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int DATA_W   = BP_DATA_W,
    parameter int LANES    = BP_LANES,
    parameter int GAP      = 4,
    parameter int OQ_DEPTH = 2
) (
    input  logic                    clk_b,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_keep,
    output logic                    out_last,
    output logic                    overflow,
    output logic [BP_LEN_W-1:0]     burst_len
);

    localparam int WORD_W = LANES * DATA_W;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    // A one-lane word is complete as soon as its first byte lands.
    localparam bp_state_t START_STATE = (LANES == 1) ? BP_HOLD_S : BP_FILL_S;

    bp_state_t           state_reg, state_next;
    logic [LIDX_W-1:0]   lane_reg, lane_next;
    logic [7:0]          gap_reg, gap_next;
    logic [WORD_W-1:0]   word_reg, word_next;
    logic [WORD_W-1:0]   fill_word;
    logic [WORD_W-1:0]   start_word;
    logic [LANES-1:0]    part_keep;
    logic                gap_hit;
    logic                lane_last;
    logic [BP_LEN_W-1:0] len_cur;

    logic      push_c;
    bp_entry_t push_entry_c;
    logic      push_valid_reg;
    bp_entry_t push_entry_reg;

    bp_entry_t head;
    logic      oq_full;
    logic      drop;
    logic      overflow_reg;

    // Per-lane views of the word being assembled.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign fill_word[gi*DATA_W +: DATA_W] =
                (lane_reg == LIDX_W'(gi)) ? in_data : word_reg[gi*DATA_W +: DATA_W];
            if (gi == 0) begin : g_first
                assign start_word[gi*DATA_W +: DATA_W] = in_data;
            end else begin : g_rest
                // Upper lanes start cleared so a short final word carries zeros.
                assign start_word[gi*DATA_W +: DATA_W] = '0;
            end
            assign part_keep[gi] = (LIDX_W'(gi) < lane_reg);
        end
    endgenerate

    assign gap_hit   = ((gap_reg + 8'd1) == 8'(GAP));
    assign lane_last = (lane_reg == LIDX_W'(LANES - 1));

`ifdef BYTE_PACKER_LEN_EN
    logic [BP_LEN_W-1:0] cnt_reg;

    always_ff @(posedge clk_b) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (in_valid) begin
            if (state_reg == BP_IDLE_S) begin
                cnt_reg <= BP_LEN_W'(1);
            end else if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + BP_LEN_W'(1);
            end
        end
    end

    assign len_cur = cnt_reg;
`else
    assign len_cur = '0;
`endif

    always_comb begin
        state_next   = state_reg;
        lane_next    = lane_reg;
        gap_next     = gap_reg;
        word_next    = word_reg;
        push_c       = 1'b0;
        push_entry_c = '0;
        case (state_reg)
            BP_IDLE_S: begin
                if (in_valid) begin
                    word_next  = start_word;
                    lane_next  = LIDX_W'(1);
                    gap_next   = 8'd0;
                    state_next = START_STATE;
                end
            end
            BP_FILL_S: begin
                if (in_valid) begin
                    word_next = fill_word;
                    gap_next  = 8'd0;
                    if (lane_last) begin
                        lane_next  = '0;
                        state_next = BP_HOLD_S;
                    end else begin
                        lane_next = lane_reg + LIDX_W'(1);
                    end
                end else if (gap_hit) begin
                    push_c            = 1'b1;
                    push_entry_c.data = word_reg;
                    push_entry_c.keep = part_keep;
                    push_entry_c.last = 1'b1;
                    push_entry_c.len  = len_cur;
                    lane_next         = '0;
                    gap_next          = 8'd0;
                    state_next        = BP_IDLE_S;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            BP_HOLD_S: begin
                // The held word is only released once we know whether
                // another byte follows it (last=0) or the burst ended (last=1).
                if (in_valid) begin
                    push_c            = 1'b1;
                    push_entry_c.data = word_reg;
                    push_entry_c.keep = '1;
                    push_entry_c.last = 1'b0;
                    word_next         = start_word;
                    lane_next         = LIDX_W'(1);
                    gap_next          = 8'd0;
                    state_next        = START_STATE;
                end else if (gap_hit) begin
                    push_c            = 1'b1;
                    push_entry_c.data = word_reg;
                    push_entry_c.keep = '1;
                    push_entry_c.last = 1'b1;
                    push_entry_c.len  = len_cur;
                    lane_next         = '0;
                    gap_next          = 8'd0;
                    state_next        = BP_IDLE_S;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: begin
                state_next = BP_IDLE_S;
            end
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            state_reg      <= BP_IDLE_S;
            lane_reg       <= '0;
            gap_reg        <= 8'd0;
            word_reg       <= '0;
            push_valid_reg <= 1'b0;
            push_entry_reg <= '0;
        end else begin
            state_reg      <= state_next;
            lane_reg       <= lane_next;
            gap_reg        <= gap_next;
            word_reg       <= word_next;
            // Pushes are registered one stage before entering the queue.
            push_valid_reg <= push_c;
            push_entry_reg <= push_entry_c;
        end
    end

    byte_packer_oq #(
        .DEPTH (OQ_DEPTH)
    ) u_oq (
        .clk        (clk_b),
        .srst       (rst),
        .push       (push_valid_reg),
        .push_entry (push_entry_reg),
        .pop_ready  (out_ready),
        .head_valid (out_valid),
        .head       (head),
        .full       (oq_full)
    );

    assign drop = push_valid_reg && oq_full && !(out_valid && out_ready);

    always_ff @(posedge clk_b) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow  = overflow_reg;
    assign out_data  = head.data;
    assign out_keep  = head.keep;
    assign out_last  = head.last;
    // len is only ever non-zero on last entries, and only when counting is built.
    assign burst_len = (out_valid && head.last) ? head.len : '0;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer
//   Self-checking bench for byte_packer. A byte-queue reference model
//   predicts the output queue contents every cycle; directed bursts pin the
//   model with literal words, then a randomized phase runs against the model.
//   Honours BYTE_PACKER_LEN_EN for the burst_len expectations.
module tb_byte_packer;

    localparam int GAP   = 4;
    localparam int LANES = 4;

    logic        clk_b = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        overflow;
    logic [15:0] burst_len;

    always #5 clk_b = ~clk_b;

    byte_packer #(
        .DATA_W   (8),
        .LANES    (LANES),
        .GAP      (GAP),
        .OQ_DEPTH (2)
    ) dut (
        .clk_b     (clk_b),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .overflow  (overflow),
        .burst_len (burst_len)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          len;
    } word_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [15:0] len;
        int          cyc;
    } xfer_t;

    word_t      mq[$];
    logic [7:0] cur_bytes[$];
    xfer_t      log_q[$];
    int         idle_cnt = 0;
    int         burst_cnt = 0;
    bit         pend_v = 0;
    word_t      pend;
    bit         m_ovf = 0;
    int         cyc = 0;
    int         last_byte_cyc = 0;
    bit         started = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic word_t make_word(input bit last);
        word_t w;
        w.data = 32'h0;
        for (int i = 0; i < cur_bytes.size(); i++) begin
            w.data[8*i +: 8] = cur_bytes[i];
        end
        w.keep = 4'((1 << cur_bytes.size()) - 1);
        w.last = last;
        w.len  = last ? ((burst_cnt > 65535) ? 65535 : burst_cnt) : 0;
        return w;
    endfunction

    // Reference model: bytes accumulate per word; a full word is released
    // when the next byte arrives, the last word after GAP idle cycles. A
    // released word enters the 2-deep queue one edge later.
    always @(posedge clk_b) begin
        cyc++;
        if (out_valid === 1'b1 && out_ready) begin
            log_q.push_back('{out_data, out_keep, out_last, burst_len, cyc});
        end
        if (rst) begin
            mq.delete();
            cur_bytes.delete();
            idle_cnt  = 0;
            burst_cnt = 0;
            pend_v    = 0;
            m_ovf     = 0;
        end else begin
            if (mq.size() > 0 && out_ready) begin
                void'(mq.pop_front());
            end
            if (pend_v) begin
                if (mq.size() < 2) mq.push_back(pend);
                else m_ovf = 1;
                pend_v = 0;
            end
            if (in_valid) begin
                last_byte_cyc = cyc;
                if (cur_bytes.size() == 0) burst_cnt = 0;
                if (cur_bytes.size() == LANES) begin
                    pend   = make_word(1'b0);
                    pend_v = 1;
                    cur_bytes.delete();
                end
                cur_bytes.push_back(in_data);
                burst_cnt++;
                idle_cnt = 0;
            end else if (cur_bytes.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == GAP) begin
                    pend   = make_word(1'b1);
                    pend_v = 1;
                    cur_bytes.delete();
                    idle_cnt = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_b) begin
        if (started) begin
            logic        exp_v;
            logic [15:0] exp_len;
            exp_v   = (mq.size() > 0);
            exp_len = 16'h0;
            check("out_valid", out_valid, exp_v);
            check("overflow", overflow, m_ovf);
            if (exp_v) begin
                check("out_data", out_data, mq[0].data);
                check("out_keep", out_keep, mq[0].keep);
                check("out_last", out_last, mq[0].last);
`ifdef BYTE_PACKER_LEN_EN
                exp_len = mq[0].last ? 16'(mq[0].len) : 16'h0;
`endif
            end
            check("burst_len", burst_len, exp_len);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk_b);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic expect_word(input string name, input int idx, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        if (log_q.size() > idx) begin
            check({name, " data"}, log_q[idx].data, d);
            check({name, " keep"}, log_q[idx].keep, k);
            check({name, " last"}, log_q[idx].last, l);
        end else begin
            check({name, " present"}, log_q.size(), idx + 1);
        end
    endtask

    task automatic expect_len(input string name, input int idx, input int len);
`ifdef BYTE_PACKER_LEN_EN
        if (log_q.size() > idx) check({name, " burst_len"}, log_q[idx].len, len);
        else check({name, " len present"}, log_q.size(), idx + 1);
`else
        if (log_q.size() > idx) check({name, " burst_len"}, log_q[idx].len, 0);
        else check({name, " len present"}, log_q.size(), idx + 1 + len - len);
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_b);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, 32'h0);
        check("reset out_keep", out_keep, 4'h0);
        check("reset out_last", out_last, 1'b0);
        check("reset overflow", overflow, 1'b0);
        check("reset burst_len", burst_len, 16'h0);
        started = 1;
        rst = 1'b0;
        idle(2);

        // 1: eight bytes, two full words
        log_q.delete();
        for (int b = 1; b <= 8; b++) drive(1'b1, 8'(b));
        idle(GAP + 6);
        check("t1 count", log_q.size(), 2);
        expect_word("t1 w0", 0, 32'h04030201, 4'hF, 1'b0);
        expect_word("t1 w1", 1, 32'h08070605, 4'hF, 1'b1);
        expect_len("t1 w1", 1, 8);
        if (log_q.size() > 1) check("t1 last latency", log_q[1].cyc - last_byte_cyc, GAP + 2);

        // 2: six bytes, partial final word
        log_q.delete();
        for (int b = 0; b < 6; b++) drive(1'b1, 8'hA0 + 8'(b));
        idle(GAP + 6);
        check("t2 count", log_q.size(), 2);
        expect_word("t2 w0", 0, 32'hA3A2A1A0, 4'hF, 1'b0);
        expect_word("t2 w1", 1, 32'h0000A5A4, 4'h3, 1'b1);
        expect_len("t2 w1", 1, 6);

        // 3: short gap inside a burst is tolerated
        log_q.delete();
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        idle(3);
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        idle(GAP + 6);
        check("t3 count", log_q.size(), 1);
        expect_word("t3 w0", 0, 32'h44332211, 4'hF, 1'b1);
        expect_len("t3 w0", 0, 4);

        // 4: stalled consumer, overflow, then drain
        log_q.delete();
        @(negedge clk_b);
        out_ready = 1'b0;
        for (int b = 0; b < 16; b++) drive(1'b1, 8'hC0 + 8'(b));
        idle(GAP + 8);
        check("t4 overflow", overflow, 1'b1);
        check("t4 held count", log_q.size(), 0);
        @(negedge clk_b);
        out_ready = 1'b1;
        idle(6);
        check("t4 count", log_q.size(), 2);
        expect_word("t4 w0", 0, 32'hC3C2C1C0, 4'hF, 1'b0);
        expect_word("t4 w1", 1, 32'hC7C6C5C4, 4'hF, 1'b0);

        // 5: reset mid-burst discards the partial word
        log_q.delete();
        for (int b = 0; b < 3; b++) drive(1'b1, 8'hD0 + 8'(b));
        @(negedge clk_b);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk_b);
        rst = 1'b0;
        check("t5 overflow cleared", overflow, 1'b0);
        for (int b = 0; b < 4; b++) drive(1'b1, 8'hB0 + 8'(b));
        idle(GAP + 6);
        check("t5 count", log_q.size(), 1);
        expect_word("t5 w0", 0, 32'hB3B2B1B0, 4'hF, 1'b1);
        expect_len("t5 w0", 0, 4);

        // 6: single byte
        log_q.delete();
        drive(1'b1, 8'h5A);
        idle(GAP + 6);
        check("t6 count", log_q.size(), 1);
        expect_word("t6 w0", 0, 32'h0000005A, 4'h1, 1'b1);
        expect_len("t6 w0", 0, 1);

        // Randomized phase, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_b);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = (i % 997 == 996);
        end
        @(negedge clk_b);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(GAP + 10);
        check("final queue drained", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
